uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver, 8N1 (8E1/8O1 with parity option), LSB first.
//  Mirror of the team's UART transmitter: recovers bytes from the game-controller
//  serial link and presents each byte as a one-cycle valid strobe to the core logic.
//  Samples at mid-bit using a clock-cycle counter; no oversampling majority vote.
// PARAMETERS
//  c_CYCLES_PER_BIT  434  clock cycles per bit (50 MHz / 115200 baud); must be >= 4
//  c_PARITY_ODD      0    parity sense when parity compiled in: 0 = even, 1 = odd
// PORTS
//  i_CLK            in   1  single system clock, all logic on rising edge
//  i_RESET          in   1  synchronous reset, active-high
//  i_SERIAL_DATA    in   1  asynchronous serial line, idles high
//  o_PARALLEL_DATA  out  8  last good received byte, stable until next good byte
//  o_RX_DV          out  1  one-cycle pulse: o_PARALLEL_DATA updated this cycle
//  o_RX_ACTIVE      out  1  high from start-bit detect until return to IDLE
//  o_FRAMING_ERR    out  1  one-cycle pulse: stop bit sampled low
//  o_PARITY_ERR     out  1  one-cycle pulse with o_RX_DV on parity mismatch
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counter 0; bit index 0; synchronizer flops 1.
//  Input passes a 2-flop synchronizer; "line" below means synchronizer output.
//  Counter: 32-bit, cleared on every state transition.
//  IDLE: watch for falling edge (previous line 1, current 0) -> START, RX_ACTIVE=1.
//    A line held low (break) does not retrigger; a new high->low edge is required.
//  START: count to c_CYCLES_PER_BIT/2 - 1 (integer division), then sample line:
//    0 -> DATA; 1 -> glitch, back to IDLE, no output pulses.
//  DATA: count to c_CYCLES_PER_BIT-1, sample line into shift register bit[index],
//    index 0..7; after index 7 -> PARITY (if compiled) else STOP.
//  PARITY: count to c_CYCLES_PER_BIT-1, sample and store parity bit -> STOP.
//  STOP: count to c_CYCLES_PER_BIT-1, sample line:
//    1 -> CLEANUP with good-frame flag; 0 -> CLEANUP with framing-error flag.
//  CLEANUP (one cycle): good -> o_RX_DV=1 and o_PARALLEL_DATA <= shift register;
//    framing error -> o_FRAMING_ERR=1, o_RX_DV=0, o_PARALLEL_DATA unchanged.
//    Then IDLE, RX_ACTIVE=0. Previous-line edge detector primed to 1 so a start bit
//    that begins directly after the mid-stop sample is still caught.
//  Latency: o_RX_DV rises 1 cycle after the mid-stop-bit sample cycle.
//  All pulses are exactly one cycle; never asserted outside CLEANUP.
//  Reset mid-frame: immediate return to reset values; partial byte discarded.
//  Undefined state encodings recover to IDLE.
// CONFIGURATION
//  Macro UART_RX_PARITY_EN:
//   defined   -> PARITY state present; frame is start+8 data+parity+stop.
//                Expected parity = ^data ^ c_PARITY_ODD; mismatch on a good stop bit
//                -> o_PARITY_ERR=1 in the same cycle as o_RX_DV (data still delivered).
//                Framing error takes precedence: no DV, no PARITY_ERR.
//   undefined -> no PARITY state, 8N1 frame; o_PARITY_ERR tied 0; c_PARITY_ODD ignored.
// TESTING  (bench uses c_CYCLES_PER_BIT=16)
//  1 8N1 frame 0xA5 at 16 cycles/bit -> single o_RX_DV pulse, data=0xA5, errs 0.
//  2 Line low 5 cycles then high -> no pulses, RX_ACTIVE drops after half-bit check.
//  3 Frame 0x3C with stop bit 0, after good 0xA5 -> FRAMING_ERR pulse, no DV, data=0xA5.
//  4 Frames 0x00 then 0xFF back-to-back, no idle gap -> two DV pulses, data 0x00, 0xFF.
//  5 i_RESET high 1 cycle in DATA bit 3 -> outputs 0, IDLE; next frame 0x5A received ok.
//  6 UART_RX_PARITY_EN, even: 0x01 with parity 0 -> DV + PARITY_ERR; parity 1 -> DV only.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and received-byte outputs of uart_rx
interface uart_rx_if;
  logic       i_SERIAL_DATA;
  logic [7:0] o_PARALLEL_DATA;
  logic       o_RX_DV;
  logic       o_RX_ACTIVE;
  logic       o_FRAMING_ERR;
  logic       o_PARITY_ERR;

  modport master (
    input  i_SERIAL_DATA,
    output o_PARALLEL_DATA, o_RX_DV, o_RX_ACTIVE, o_FRAMING_ERR, o_PARITY_ERR
  );

  modport slave (
    output i_SERIAL_DATA,
    input  o_PARALLEL_DATA, o_RX_DV, o_RX_ACTIVE, o_FRAMING_ERR, o_PARITY_ERR
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1, mid-bit sampling, LSB first
// Optional parity bit (8E1/8O1) when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int c_CYCLES_PER_BIT = 434,
  parameter int c_PARITY_ODD     = 0
) (
  input  logic     i_CLK,
  input  logic     i_RESET,
  uart_rx_if.master rx
);

  localparam logic [31:0] c_HALF_M1 = 32'(c_CYCLES_PER_BIT / 2 - 1);
  localparam logic [31:0] c_FULL_M1 = 32'(c_CYCLES_PER_BIT - 1);

  generate
    if (c_CYCLES_PER_BIT < 4 || c_PARITY_ODD < 0 || c_PARITY_ODD > 1) begin : g_param_check
      $error("uart_rx: c_CYCLES_PER_BIT must be >= 4 and c_PARITY_ODD 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY  = 3'd3,
`endif
    ST_STOP    = 3'd4,
    ST_CLEANUP = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        rx_dv_q, rx_dv_d;
  logic        active_q, active_d;
  logic        framing_err_q, framing_err_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_line_q, prev_line_d;
`ifdef UART_RX_PARITY_EN
  localparam logic c_ODD_BIT = (c_PARITY_ODD != 0);
  logic        parity_q, parity_d;
  logic        parity_err_q, parity_err_d;
`endif

  logic line;
  assign line = sync2_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 32'd1;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    data_d        = data_q;
    rx_dv_d       = 1'b0;
    framing_err_d = 1'b0;
    active_d      = active_q;
    sync1_d       = rx.i_SERIAL_DATA;
    sync2_d       = sync1_q;
    prev_line_d   = line;
`ifdef UART_RX_PARITY_EN
    parity_d      = parity_q;
    parity_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (prev_line_q && !line) begin
          state_d  = ST_START;
          active_d = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == c_HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          if (line) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == c_FULL_M1) begin
          cnt_d             = '0;
          shift_d[bit_idx_q] = line;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == c_FULL_M1) begin
          cnt_d    = '0;
          parity_d = line;
          state_d  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Pulses are registered here so they are high exactly during CLEANUP.
        if (cnt_q == c_FULL_M1) begin
          cnt_d   = '0;
          state_d = ST_CLEANUP;
          if (line) begin
            rx_dv_d = 1'b1;
            data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
            parity_err_d = (parity_q != (^shift_q ^ c_ODD_BIT));
`endif
          end else begin
            framing_err_d = 1'b1;
          end
        end
      end
      ST_CLEANUP: begin
        // Priming lets a start bit that follows the stop bit immediately be seen.
        cnt_d       = '0;
        state_d     = ST_IDLE;
        active_d    = 1'b0;
        prev_line_d = 1'b1;
      end
      default: begin
        cnt_d    = '0;
        state_d  = ST_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      rx_dv_q       <= 1'b0;
      active_q      <= 1'b0;
      framing_err_q <= 1'b0;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_line_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_q      <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      rx_dv_q       <= rx_dv_d;
      active_q      <= active_d;
      framing_err_q <= framing_err_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_line_q   <= prev_line_d;
`ifdef UART_RX_PARITY_EN
      parity_q      <= parity_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx.o_PARALLEL_DATA = data_q;
  assign rx.o_RX_DV         = rx_dv_q;
  assign rx.o_RX_ACTIVE     = active_q;
  assign rx.o_FRAMING_ERR   = framing_err_q;
`ifdef UART_RX_PARITY_EN
  assign rx.o_PARITY_ERR    = parity_err_q;
`else
  assign rx.o_PARITY_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at 16 cycles/bit
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_LEN = (10 + PAR) * CPB;
  // line change visible after 2 sync flops, start sampled half a bit later,
  // stop sampled (9+PAR) bits after that, strobe one cycle after the sample
  localparam int DV_LAT = 2 + CPB / 2 + (9 + PAR) * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if rx_if();
  uart_rx #(.c_CYCLES_PER_BIT(CPB), .c_PARITY_ODD(ODD)) dut (
    .i_CLK   (clk),
    .i_RESET (rst),
    .rx      (rx_if)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] dv_data_q[$];
  int         dv_cyc_q[$];
  int         fe_cnt, pe_cnt, width_err, stray;
  logic       prev_dv = 1'b0, prev_fe = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.o_RX_DV) begin
        dv_data_q.push_back(rx_if.o_PARALLEL_DATA);
        dv_cyc_q.push_back(cyc);
      end
      if (rx_if.o_FRAMING_ERR) fe_cnt++;
      if (rx_if.o_PARITY_ERR) pe_cnt++;
      if (rx_if.o_PARITY_ERR && !rx_if.o_RX_DV) stray++;
      if (rx_if.o_RX_DV && rx_if.o_FRAMING_ERR) stray++;
      if ((rx_if.o_RX_DV && prev_dv) || (rx_if.o_FRAMING_ERR && prev_fe)) width_err++;
    end
    prev_dv = rx_if.o_RX_DV;
    prev_fe = rx_if.o_FRAMING_ERR;
  end

  function automatic logic exp_par(input logic [7:0] d);
    return (^d) ^ (ODD != 0);
  endfunction

  task automatic clear_log();
    dv_data_q.delete();
    dv_cyc_q.delete();
    fe_cnt = 0; pe_cnt = 0; width_err = 0; stray = 0;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_if.i_SERIAL_DATA = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            output int p_start);
    p_start = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    if (PAR != 0) drive_bit(par, CPB);
    drive_bit(stop, CPB);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_if.i_SERIAL_DATA = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    vectors++;
    if (rx_if.o_PARALLEL_DATA !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", rx_if.o_PARALLEL_DATA); end
    vectors++;
    if (rx_if.o_RX_DV !== 1'b0) begin miscompares++; $display("FAIL reset_dv: got %b expected 0", rx_if.o_RX_DV); end
    vectors++;
    if (rx_if.o_RX_ACTIVE !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b expected 0", rx_if.o_RX_ACTIVE); end
    vectors++;
    if ({rx_if.o_FRAMING_ERR, rx_if.o_PARITY_ERR} !== 2'b00) begin
      miscompares++; $display("FAIL reset_errs: got %b expected 00", {rx_if.o_FRAMING_ERR, rx_if.o_PARITY_ERR});
    end
    idle(4);
  endtask

  task automatic test_single();
    int p;
    clear_log();
    send_frame(8'hA5, 1'b1, exp_par(8'hA5), p);
    idle(20);
    vectors++;
    if (dv_data_q.size() !== 1) begin
      miscompares++; $display("FAIL single_dv_count: got %0d expected 1", dv_data_q.size());
    end else begin
      vectors++;
      if (dv_data_q[0] !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h expected a5", dv_data_q[0]); end
      check_int("single_latency", dv_cyc_q[0] - p, DV_LAT);
    end
    check_int("single_fe", fe_cnt, 0);
    check_int("single_pe", pe_cnt, 0);
  endtask

  task automatic test_glitch();
    clear_log();
    drive_bit(1'b0, 5);
    vectors++;
    if (rx_if.o_RX_ACTIVE !== 1'b1) begin miscompares++; $display("FAIL glitch_active_hi: got %b expected 1", rx_if.o_RX_ACTIVE); end
    idle(10);
    vectors++;
    if (rx_if.o_RX_ACTIVE !== 1'b0) begin miscompares++; $display("FAIL glitch_active_lo: got %b expected 0", rx_if.o_RX_ACTIVE); end
    idle(20);
    check_int("glitch_pulses", dv_data_q.size() + fe_cnt + pe_cnt, 0);
  endtask

  task automatic test_framing();
    int p;
    clear_log();
    send_frame(8'hA5, 1'b1, exp_par(8'hA5), p);
    send_frame(8'h3C, 1'b0, exp_par(8'h3C), p);
    idle(40);
    check_int("framing_dv_count", dv_data_q.size(), 1);
    check_int("framing_fe_count", fe_cnt, 1);
    vectors++;
    if (rx_if.o_PARALLEL_DATA !== 8'hA5) begin miscompares++; $display("FAIL framing_data_hold: got %h expected a5", rx_if.o_PARALLEL_DATA); end
    check_int("framing_pe", pe_cnt, 0);
  endtask

  task automatic test_back_to_back();
    int p0, p1;
    clear_log();
    send_frame(8'h00, 1'b1, exp_par(8'h00), p0);
    send_frame(8'hFF, 1'b1, exp_par(8'hFF), p1);
    idle(20);
    vectors++;
    if (dv_data_q.size() !== 2) begin
      miscompares++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_data_q.size());
    end else begin
      vectors++;
      if (dv_data_q[0] !== 8'h00 || dv_data_q[1] !== 8'hFF) begin
        miscompares++; $display("FAIL b2b_data: got %h %h expected 00 ff", dv_data_q[0], dv_data_q[1]);
      end
      check_int("b2b_spacing", dv_cyc_q[1] - dv_cyc_q[0], FRAME_LEN);
    end
    check_int("b2b_fe", fe_cnt, 0);
  endtask

  task automatic test_reset_mid_frame();
    int p;
    logic [7:0] partial;
    partial = 8'h96;
    clear_log();
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(partial[i], CPB);
    drive_bit(partial[3], CPB / 2);
    rst = 1'b1;
    rx_if.i_SERIAL_DATA = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (rx_if.o_RX_ACTIVE !== 1'b0 || rx_if.o_PARALLEL_DATA !== 8'h00 || rx_if.o_RX_DV !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got active=%b data=%h dv=%b expected 0 00 0",
               rx_if.o_RX_ACTIVE, rx_if.o_PARALLEL_DATA, rx_if.o_RX_DV);
    end
    idle(5);
    send_frame(8'h5A, 1'b1, exp_par(8'h5A), p);
    idle(20);
    vectors++;
    if (dv_data_q.size() !== 1 || dv_data_q[0] !== 8'h5A) begin
      miscompares++; $display("FAIL midreset_next_frame: got count=%0d expected one 5a", dv_data_q.size());
    end
    check_int("midreset_fe", fe_cnt, 0);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int p;
    clear_log();
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, 1'b1, exp_par(d), p);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 20));
    end
    idle(30);
    check_int("random_dv_count", dv_data_q.size(), exp_q.size());
    for (int n = 0; n < exp_q.size() && n < dv_data_q.size(); n++) begin
      vectors++;
      if (dv_data_q[n] !== exp_q[n]) begin
        miscompares++; $display("FAIL random_data[%0d]: got %h expected %h", n, dv_data_q[n], exp_q[n]);
      end
    end
    check_int("random_errs", fe_cnt + pe_cnt, 0);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p;
    clear_log();
    send_frame(8'h01, 1'b1, 1'b0, p);
    idle(10);
    check_int("parity_bad_dv", dv_data_q.size(), 1);
    check_int("parity_bad_pe", pe_cnt, 1);
    clear_log();
    send_frame(8'h01, 1'b1, 1'b1, p);
    idle(10);
    check_int("parity_good_dv", dv_data_q.size(), 1);
    check_int("parity_good_pe", pe_cnt, 0);
    clear_log();
    send_frame(8'h01, 1'b0, 1'b0, p);
    idle(40);
    check_int("parity_fe_precedence", dv_data_q.size() * 10 + pe_cnt, 0);
    check_int("parity_fe_count", fe_cnt, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    check_int("pulse_width", width_err, 0);
    check_int("stray_pulses", stray, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
